fetch_sequencer: RTL and testbench
==================================

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter RESET_PC, default 32'h0: word address fetched first after reset.
REQ-002 Parameter PC_STEP, default 32'd1: sequential PC increment; instruction memory is word-indexed.
REQ-003 clk  input  1  sole clock; all state updates on posedge clk.
REQ-004 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 EX_branch_flag  input  1  branch taken in EX; redirect to EX_ALUout.
REQ-006 EX_jump_flag  input  1  jump in EX; redirect to EX_jump_addr.
REQ-007 EX_ALUout  input  32  branch target.
REQ-008 EX_jump_addr  input  32  jump target.
REQ-009 imem_req  output  1  instruction memory request; held high until imem_ack.
REQ-010 imem_addr  output  32  request address; stable while imem_req high.
REQ-011 imem_ack  input  1  memory returns imem_rdata this cycle; ignored unless imem_req high.
REQ-012 imem_rdata  input  32  instruction word, valid with imem_ack.
REQ-013 IF_valid  output  1  IF_IR/IF_PC hold a valid instruction.
REQ-014 ID_ready  input  1  decode accepts instruction when IF_valid && ID_ready.
REQ-015 IF_IR  output  32  fetched instruction.
REQ-016 IF_PC  output  32  address of IF_IR.
REQ-017 IF_redirect_cnt  output  16  count of accepted redirects, saturating at 16'hFFFF.

Function
REQ-018 FSM states SHALL be: IDLE, REQ, HOLD, DRAIN.
REQ-019 IDLE: one cycle after reset release; next state REQ with imem_addr = PC.
REQ-020 REQ: imem_req=1; on imem_ack with no redirect, register imem_rdata into IF_IR and PC into IF_PC, go HOLD (IF_valid=1 next cycle).
REQ-021 HOLD: IF_valid=1, IF_IR/IF_PC stable; on ID_ready, PC <= PC+PC_STEP, go REQ in same edge (next request issued following cycle).
REQ-022 Redirect = EX_branch_flag | EX_jump_flag; branch SHALL take priority over jump when both high.
REQ-023 Redirect in IDLE or HOLD: PC <= target, IF_valid cleared next cycle, held instruction discarded even if ID_ready high that cycle, go REQ.
REQ-024 Redirect in REQ without imem_ack: PC <= target, go DRAIN; imem_req/imem_addr stay unchanged until ack.
REQ-025 Redirect in REQ with imem_ack: returned word discarded, PC <= target, go REQ.
REQ-026 DRAIN: imem_req=1 at old address; on imem_ack, discard data, go REQ; a further redirect in DRAIN updates PC only.
REQ-027 IF_valid SHALL never be 1 in REQ, DRAIN or IDLE.
REQ-028 PC arithmetic modulo 2^32; 32'hFFFFFFFF + 1 wraps to 0.
REQ-029 IF_redirect_cnt increments by 1 per cycle with redirect asserted, saturates, never wraps.

Reset
REQ-030 On reset low, asynchronously: state=IDLE, PC=RESET_PC, imem_req=0, imem_addr=RESET_PC, IF_valid=0, IF_IR=0, IF_PC=0, IF_redirect_cnt=0.
REQ-031 Reset mid-request SHALL abandon the outstanding access; acks during or first cycle after reset are ignored.

Structure
REQ-032 Shared package fetch_pkg SHALL hold the state enum, RESET_PC and PC_STEP defaults.
REQ-033 Next-PC priority select (reset/branch/jump/step) SHALL be sub-module pc_select; FSM and registers in fetch_sequencer.

Verification
REQ-034 Reset release, ack every cycle after req, ID_ready=1 -> imem_addr 0,1,2; IF_PC 0,1,2 with IF_valid.
REQ-035 HOLD at PC 5, ID_ready=0 for 4 cycles -> IF_IR/IF_PC stable, imem_req=0, no PC advance.
REQ-036 REQ at PC 3, ack delayed 3 cycles, branch to 32'h40 in cycle 1 -> DRAIN, addr 3 kept, word discarded, next request addr 32'h40, IF_redirect_cnt=1.
REQ-037 Branch 32'h10 and jump 32'h20 same cycle in HOLD -> next imem_addr=32'h10, held instruction not delivered.
REQ-038 PC=32'hFFFFFFFF accepted -> next imem_addr=0.
REQ-039 reset low during REQ with ack pending -> all outputs reset values immediately; first post-reset imem_addr=RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch sequencer.
package fetch_pkg;
  localparam logic [31:0] RESET_PC_DEF = 32'h0;
  localparam logic [31:0] PC_STEP_DEF  = 32'd1;

  typedef enum logic [1:0] {IDLE, REQ, HOLD, DRAIN} fetch_state_e;

  typedef struct packed {
    logic        branch;
    logic        jump;
    logic [31:0] br_target;
    logic [31:0] jmp_target;
  } redirect_t;
endpackage

// File: rtl/fetch_sequencer_pc_select.sv
// Next-PC priority mux: branch over jump over sequential step, else hold.
module pc_select
  import fetch_pkg::*;
#(
  parameter logic [31:0] PC_STEP = PC_STEP_DEF
) (
  input  redirect_t   redir,
  input  logic        step,
  input  logic [31:0] pc,
  output logic [31:0] pc_next,
  output logic        redirect
);
  assign redirect = redir.branch | redir.jump;

  always_comb begin
    pc_next = pc;
    if (redir.branch)    pc_next = redir.br_target;
    else if (redir.jump) pc_next = redir.jmp_target;
    else if (step)       pc_next = pc + PC_STEP;
  end
endmodule

// File: rtl/fetch_sequencer.sv
// Single-outstanding instruction fetch FSM with EX redirects and a decode handshake.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter logic [31:0] PC_STEP  = PC_STEP_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        EX_branch_flag,
  input  logic        EX_jump_flag,
  input  logic [31:0] EX_ALUout,
  input  logic [31:0] EX_jump_addr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        IF_valid,
  input  logic        ID_ready,
  output logic [31:0] IF_IR,
  output logic [31:0] IF_PC,
  output logic [15:0] IF_redirect_cnt
);
  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_next;
  logic         redirect, step, load_addr, capture;
  redirect_t    redir;

  assign redir = '{branch: EX_branch_flag, jump: EX_jump_flag,
                   br_target: EX_ALUout, jmp_target: EX_jump_addr};
  assign step  = (state_q == HOLD) && ID_ready;

  pc_select #(.PC_STEP(PC_STEP)) u_pc_select (
    .redir    (redir),
    .step     (step),
    .pc       (pc_q),
    .pc_next  (pc_next),
    .redirect (redirect)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = REQ;
      REQ:     if (imem_ack)            state_d = redirect ? REQ : HOLD;
               else if (redirect)       state_d = DRAIN;
      HOLD:    if (redirect || ID_ready) state_d = REQ;
      DRAIN:   if (imem_ack)            state_d = REQ;
      default: state_d = IDLE;
    endcase
  end

  // A new address is launched on every entry into REQ except while an access
  // is still outstanding (REQ without ack keeps its address stable).
  assign load_addr = (state_d == REQ) && ((state_q != REQ) || imem_ack);
  assign capture   = (state_q == REQ) && imem_ack && !redirect;
  assign imem_req  = (state_q == REQ) || (state_q == DRAIN);
  assign IF_valid  = (state_q == HOLD);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= IDLE;
      pc_q            <= RESET_PC;
      imem_addr       <= RESET_PC;
      IF_IR           <= '0;
      IF_PC           <= '0;
      IF_redirect_cnt <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_next;
      if (load_addr) imem_addr <= pc_next;
      if (capture) begin
        IF_IR <= imem_rdata;
        IF_PC <= imem_addr;
      end
      if (redirect && (IF_redirect_cnt != 16'hFFFF))
        IF_redirect_cnt <= IF_redirect_cnt + 16'd1;
    end
  end
endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed per-cycle vector bench for fetch_sequencer plus a mid-request reset sequence.
module tb_fetch_sequencer;
  logic        clk, reset;
  logic        EX_branch_flag, EX_jump_flag;
  logic [31:0] EX_ALUout, EX_jump_addr;
  logic        imem_req, imem_ack;
  logic [31:0] imem_addr, imem_rdata;
  logic        IF_valid, ID_ready;
  logic [31:0] IF_IR, IF_PC;
  logic [15:0] IF_redirect_cnt;

  int checks = 0;
  int errors = 0;

  fetch_sequencer dut (
    .clk(clk), .reset(reset),
    .EX_branch_flag(EX_branch_flag), .EX_jump_flag(EX_jump_flag),
    .EX_ALUout(EX_ALUout), .EX_jump_addr(EX_jump_addr),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .IF_valid(IF_valid), .ID_ready(ID_ready),
    .IF_IR(IF_IR), .IF_PC(IF_PC), .IF_redirect_cnt(IF_redirect_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        br, jp;
    logic [31:0] alu, jad;
    logic        ack;
    logic [31:0] rdata;
    logic        rdy;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_vld;
    logic [31:0] e_ir, e_pc;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic vec(input logic br, jp, input logic [31:0] alu, jad,
                     input logic ack, input logic [31:0] rdata, input logic rdy,
                     input logic e_req, input logic [31:0] e_addr, input logic e_vld,
                     input logic [31:0] e_ir, e_pc, input logic [15:0] e_cnt);
    vec_t v;
    v = '{br, jp, alu, jad, ack, rdata, rdy, e_req, e_addr, e_vld, e_ir, e_pc, e_cnt};
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic e_req, input logic [31:0] e_addr,
                       input logic e_vld, input logic [31:0] e_ir, e_pc, input logic [15:0] e_cnt);
    logic [113:0] act, exp;
    act = {imem_req, imem_addr, IF_valid, IF_IR, IF_PC, IF_redirect_cnt};
    exp = {e_req, e_addr, e_vld, e_ir, e_pc, e_cnt};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got req=%b addr=%h vld=%b ir=%h pc=%h cnt=%h want req=%b addr=%h vld=%b ir=%h pc=%h cnt=%h",
               name, imem_req, imem_addr, IF_valid, IF_IR, IF_PC, IF_redirect_cnt,
               e_req, e_addr, e_vld, e_ir, e_pc, e_cnt);
    end
  endtask

  initial begin
    reset = 1'b0; EX_branch_flag = 0; EX_jump_flag = 0; EX_ALUout = 0; EX_jump_addr = 0;
    imem_ack = 0; imem_rdata = 0; ID_ready = 0;

    //  br jp alu           jad           ack rdata          rdy | req addr          vld ir             pc            cnt
    // sequential stream 0,1,2 then REQ at 3
    vec(0, 0, 0,            0,            0, 0,             0,   1, 32'h0,         0, 32'h0,         32'h0,        0);
    vec(0, 0, 0,            0,            1, 32'hC0000000,  0,   0, 32'h0,         1, 32'hC0000000,  32'h0,        0);
    vec(0, 0, 0,            0,            0, 0,             1,   1, 32'h1,         0, 32'hC0000000,  32'h0,        0);
    vec(0, 0, 0,            0,            1, 32'hC0000001,  0,   0, 32'h1,         1, 32'hC0000001,  32'h1,        0);
    vec(0, 0, 0,            0,            0, 0,             1,   1, 32'h2,         0, 32'hC0000001,  32'h1,        0);
    vec(0, 0, 0,            0,            1, 32'hC0000002,  0,   0, 32'h2,         1, 32'hC0000002,  32'h2,        0);
    vec(0, 0, 0,            0,            0, 0,             1,   1, 32'h3,         0, 32'hC0000002,  32'h2,        0);
    // branch to 0x40 while addr 3 outstanding: drain, discard, refetch at 0x40
    vec(1, 0, 32'h40,       0,            0, 0,             0,   1, 32'h3,         0, 32'hC0000002,  32'h2,        1);
    vec(0, 0, 0,            0,            0, 0,             0,   1, 32'h3,         0, 32'hC0000002,  32'h2,        1);
    vec(0, 0, 0,            0,            1, 32'hDEADBEEF,  0,   1, 32'h40,        0, 32'hC0000002,  32'h2,        1);
    vec(0, 0, 0,            0,            1, 32'hC0000040,  0,   0, 32'h40,        1, 32'hC0000040,  32'h40,       1);
    // branch+jump in HOLD with ID_ready high: branch wins, held word dropped
    vec(1, 1, 32'h10,       32'h20,       0, 0,             1,   1, 32'h10,        0, 32'hC0000040,  32'h40,       2);
    vec(0, 0, 0,            0,            1, 32'hC0000010,  0,   0, 32'h10,        1, 32'hC0000010,  32'h10,       2);
    // jump to 5, then stall decode for 4 cycles
    vec(0, 1, 0,            32'h5,        0, 0,             0,   1, 32'h5,         0, 32'hC0000010,  32'h10,       3);
    vec(0, 0, 0,            0,            1, 32'hC0000005,  0,   0, 32'h5,         1, 32'hC0000005,  32'h5,        3);
    vec(0, 0, 0,            0,            0, 0,             0,   0, 32'h5,         1, 32'hC0000005,  32'h5,        3);
    vec(0, 0, 0,            0,            0, 0,             0,   0, 32'h5,         1, 32'hC0000005,  32'h5,        3);
    vec(0, 0, 0,            0,            0, 0,             0,   0, 32'h5,         1, 32'hC0000005,  32'h5,        3);
    vec(0, 0, 0,            0,            0, 0,             0,   0, 32'h5,         1, 32'hC0000005,  32'h5,        3);
    vec(0, 0, 0,            0,            0, 0,             1,   1, 32'h6,         0, 32'hC0000005,  32'h5,        3);
    // jump with ack in REQ: word discarded, refetch at 0xFFFFFFFF, then wrap to 0
    vec(0, 1, 0,            32'hFFFFFFFF, 1, 32'hBADBAD00,  0,   1, 32'hFFFFFFFF,  0, 32'hC0000005,  32'h5,        4);
    vec(0, 0, 0,            0,            1, 32'hC0FFFFFF,  0,   0, 32'hFFFFFFFF,  1, 32'hC0FFFFFF,  32'hFFFFFFFF, 4);
    vec(0, 0, 0,            0,            0, 0,             1,   1, 32'h0,         0, 32'hC0FFFFFF,  32'hFFFFFFFF, 4);
    vec(0, 0, 0,            0,            1, 32'hC0000000,  0,   0, 32'h0,         1, 32'hC0000000,  32'h0,        4);
    vec(0, 0, 0,            0,            0, 0,             1,   1, 32'h1,         0, 32'hC0000000,  32'h0,        4);
    // second redirect while draining only moves the PC
    vec(1, 0, 32'h80,       0,            0, 0,             0,   1, 32'h1,         0, 32'hC0000000,  32'h0,        5);
    vec(0, 1, 0,            32'h90,       0, 0,             0,   1, 32'h1,         0, 32'hC0000000,  32'h0,        6);
    vec(0, 0, 0,            0,            1, 32'h11111111,  0,   1, 32'h90,        0, 32'hC0000000,  32'h0,        6);

    #12;
    check("reset_state", 0, 32'h0, 0, 32'h0, 32'h0, 16'h0);

    @(negedge clk);
    reset = 1'b1;
    foreach (vecs[i]) begin
      EX_branch_flag = vecs[i].br;  EX_jump_flag = vecs[i].jp;
      EX_ALUout      = vecs[i].alu; EX_jump_addr = vecs[i].jad;
      imem_ack       = vecs[i].ack; imem_rdata   = vecs[i].rdata;
      ID_ready       = vecs[i].rdy;
      @(posedge clk); #1;
      check($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_addr, vecs[i].e_vld,
            vecs[i].e_ir, vecs[i].e_pc, vecs[i].e_cnt);
      @(negedge clk);
    end

    // Reset while REQ at 0x90 has an ack pending; ack stays high across release
    EX_branch_flag = 0; EX_jump_flag = 0; ID_ready = 0;
    imem_ack = 1; imem_rdata = 32'h22222222;
    reset = 1'b0;
    #1;
    check("reset_async", 0, 32'h0, 0, 32'h0, 32'h0, 16'h0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    check("post_reset_req", 1, 32'h0, 0, 32'h0, 32'h0, 16'h0);
    @(negedge clk);
    imem_rdata = 32'hC0000000;
    @(posedge clk); #1;
    check("post_reset_fetch", 0, 32'h0, 1, 32'hC0000000, 32'h0, 16'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
